// File: rtl/ti_quad_pipe.sv
// ti_quad_pipe: registered 3-share threshold implementation of a quadratic
// vectorial Boolean function y = Q(x), with optional fresh-randomness remasking
// and an elastic output FIFO. Used as one masked S-box layer.
//
// Each output share is built from exactly two input shares. Share 1 uses
// shares 2,3. Share 2 uses shares 3,1. Share 3 uses shares 1,2. Every share
// has its own product terms, so no logic is shared between share cones. This
// keeps the function non-complete at the netlist level.
//
// The default QUAD value encodes y0=x0^x1x2, y1=x1^x2x3, y2=x2^x0x3 and
// y3=x3^x0x1. Bit j*WIDTH*WIDTH + i*WIDTH + k selects x_i&x_k in y_j.
module ti_quad_pipe #(
    parameter int                             WIDTH  = 4,
    parameter int                             OUT_W  = 4,
    parameter logic [OUT_W*WIDTH-1:0]         LIN    = 16'h8421,
    parameter logic [OUT_W*WIDTH*WIDTH-1:0]   QUAD   = 64'h0002_0008_0800_0040,
    parameter logic [OUT_W-1:0]               CONST  = 4'h0,
    parameter bit                             REMASK = 1'b1,
    parameter int                             DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_s1,
    input  logic [WIDTH-1:0]              in_s2,
    input  logic [WIDTH-1:0]              in_s3,
    input  logic [2*OUT_W-1:0]            rnd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_s1,
    output logic [OUT_W-1:0]              out_s2,
    output logic [OUT_W-1:0]              out_s3,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Unmasked component-function outputs of each share.
    logic [OUT_W-1:0] y1, y2, y3;
    // Remasked shares written into the FIFO.
    logic [OUT_W-1:0] o1, o2, o3;

    genvar gi, gj, gk;

    // Share component functions. There is one independent cone per output bit per share.
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_out
            localparam logic [WIDTH-1:0] LIN_J = LIN[gi*WIDTH +: WIDTH];

            logic [WIDTH*WIDTH-1:0] q1_terms;
            logic [WIDTH*WIDTH-1:0] q2_terms;
            logic [WIDTH*WIDTH-1:0] q3_terms;

            for (gj = 0; gj < WIDTH; gj++) begin : g_i
                for (gk = 0; gk < WIDTH; gk++) begin : g_k
                    localparam int QIDX = gi*WIDTH*WIDTH + gj*WIDTH + gk;
                    if ((gj < gk) && QUAD[QIDX]) begin : g_term
                        // Share 1 cross products: a2b2 ^ a2b3 ^ a3b2.
                        assign q1_terms[gj*WIDTH+gk] = (in_s2[gj] & in_s2[gk])
                                                     ^ (in_s2[gj] & in_s3[gk])
                                                     ^ (in_s3[gj] & in_s2[gk]);
                        // Share 2 cross products: a3b3 ^ a3b1 ^ a1b3.
                        assign q2_terms[gj*WIDTH+gk] = (in_s3[gj] & in_s3[gk])
                                                     ^ (in_s3[gj] & in_s1[gk])
                                                     ^ (in_s1[gj] & in_s3[gk]);
                        // Share 3 cross products: a1b1 ^ a1b2 ^ a2b1.
                        assign q3_terms[gj*WIDTH+gk] = (in_s1[gj] & in_s1[gk])
                                                     ^ (in_s1[gj] & in_s2[gk])
                                                     ^ (in_s2[gj] & in_s1[gk]);
                    end else begin : g_none
                        assign q1_terms[gj*WIDTH+gk] = 1'b0;
                        assign q2_terms[gj*WIDTH+gk] = 1'b0;
                        assign q3_terms[gj*WIDTH+gk] = 1'b0;
                    end
                end
            end

            // The constant term goes into share 1 only.
            assign y1[gi] = CONST[gi] ^ (^(LIN_J & in_s2)) ^ (^q1_terms);
            assign y2[gi] =             (^(LIN_J & in_s3)) ^ (^q2_terms);
            assign y3[gi] =             (^(LIN_J & in_s1)) ^ (^q3_terms);
        end

        // Fresh randomness re-randomises the sharing without changing its XOR.
        if (REMASK) begin : g_remask
            logic [OUT_W-1:0] r1, r2;
            assign r1 = rnd[OUT_W-1:0];
            assign r2 = rnd[2*OUT_W-1:OUT_W];
            assign o1 = y1 ^ r1;
            assign o2 = y2 ^ r2;
            assign o3 = y3 ^ r1 ^ r2;
        end else begin : g_plain
            assign o1 = y1;
            assign o2 = y2;
            assign o3 = y3;
        end
    endgenerate

    // FIFO state. The entries are small, so they live in flops. This lets reset clear
    // them and keeps the share outputs at zero after reset.
    logic [OUT_W-1:0] mem1_reg [DEPTH];
    logic [OUT_W-1:0] mem2_reg [DEPTH];
    logic [OUT_W-1:0] mem3_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W-1:0] show_ptr;
    logic [OCC_W-1:0] count_reg, count_next;
    logic             in_ready_reg, out_valid_reg;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
    endfunction

    assign push = in_valid & in_ready_reg;
    assign pop  = out_valid_reg & out_ready;

    // Next occupancy. A simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Pointers, count and handshake flags. The ready and valid flags are precomputed
    // from the next count, so neither depends combinationally on the other side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg     <= count_next;
            in_ready_reg  <= (count_next < OCC_W'(DEPTH));
            out_valid_reg <= (count_next != '0);
        end
    end

    // Entry storage. Only the tail slot is written on an accepted input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem1_reg[e] <= '0;
                mem2_reg[e] <= '0;
                mem3_reg[e] <= '0;
            end
        end else if (push) begin
            mem1_reg[wr_ptr_reg] <= o1;
            mem2_reg[wr_ptr_reg] <= o2;
            mem3_reg[wr_ptr_reg] <= o3;
        end
    end

    // While empty, show the most recently popped slot so the outputs hold their last
    // value. A new push goes to rd_ptr and never overwrites that slot while it is shown.
    assign show_ptr = out_valid_reg ? rd_ptr_reg : ptr_dec(rd_ptr_reg);

    assign out_s1    = mem1_reg[show_ptr];
    assign out_s2    = mem2_reg[show_ptr];
    assign out_s3    = mem3_reg[show_ptr];
    assign out_valid = out_valid_reg;
    assign in_ready  = in_ready_reg;
    assign occupancy = count_reg;

endmodule

// File: tb/tb_ti_quad_pipe.sv
// Directed testbench for ti_quad_pipe with the default parameters. It is table-driven
// for the share function, with hand-written sequences for FIFO and reset corner cases.
module tb_ti_quad_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_s1, in_s2, in_s3;
    logic [7:0] rnd;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_s1, out_s2, out_s3;
    logic [1:0] occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    ti_quad_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s1     (in_s1),
        .in_s2     (in_s2),
        .in_s3     (in_s3),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s1    (out_s1),
        .out_s2    (out_s2),
        .out_s3    (out_s3),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] s1, s2, s3;
        logic [7:0] rnd;
        logic [3:0] y;
    } vec_t;

    vec_t vecs [13];

    // Reference Q: y0=x0^x1x2, y1=x1^x2x3, y2=x2^x0x3, y3=x3^x0x1.
    function automatic logic [3:0] q_ref(input logic [3:0] x);
        return {x[3] ^ (x[0] & x[1]), x[2] ^ (x[0] & x[3]),
                x[1] ^ (x[2] & x[3]), x[0] ^ (x[1] & x[2])};
    endfunction

    // Cross-product term for one x_i x_k pair, taken over two shares p and q.
    function automatic logic zq(input logic [3:0] p, input logic [3:0] q,
                                input int i, input int k);
        return (p[i] & p[k]) ^ (p[i] & q[k]) ^ (q[i] & p[k]);
    endfunction

    // One output share computed from its two input shares, with p as the linear source.
    function automatic logic [3:0] fs(input logic [3:0] p, input logic [3:0] q);
        return {p[3] ^ zq(p, q, 0, 1), p[2] ^ zq(p, q, 0, 3),
                p[1] ^ zq(p, q, 2, 3), p[0] ^ zq(p, q, 1, 2)};
    endfunction

    // Expected remasked shares, packed as {o3, o2, o1}.
    function automatic logic [11:0] model(input logic [3:0] s1, input logic [3:0] s2,
                                          input logic [3:0] s3, input logic [7:0] r);
        logic [3:0] r1, r2;
        r1 = r[3:0];
        r2 = r[7:4];
        return {fs(s1, s2) ^ r1 ^ r2, fs(s3, s1) ^ r2, fs(s2, s3) ^ r1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [7:0] r);
        in_s1 = a;
        in_s2 = b;
        in_s3 = c;
        rnd   = r;
    endtask

    logic [11:0] exp_sh;
    logic [11:0] hist [$];
    logic [15:0] sb [$];
    logic [3:0]  xr, a, b;
    logic [15:0] head;

    initial begin
        // Each record is {s1, s2, s3, rnd, Q(s1^s2^s3)}.
        vecs[0]  = '{4'h7, 4'h0, 4'h0, 8'h00, 4'hE};
        vecs[1]  = '{4'hA, 4'h5, 4'hC, 8'h5A, 4'hB};
        vecs[2]  = '{4'hA, 4'h5, 4'hC, 8'h00, 4'hB};
        vecs[3]  = '{4'h0, 4'h0, 4'h0, 8'h3C, 4'h0};
        vecs[4]  = '{4'hF, 4'h0, 4'h0, 8'h00, 4'h0};
        vecs[5]  = '{4'h1, 4'h2, 4'h4, 8'hA5, 4'hE};
        vecs[6]  = '{4'h9, 4'h6, 4'h3, 8'hFF, 4'hE};
        vecs[7]  = '{4'h5, 4'h5, 4'h5, 8'h81, 4'h5};
        vecs[8]  = '{4'h3, 4'h8, 4'h0, 8'h12, 4'h7};
        vecs[9]  = '{4'h6, 4'h6, 4'hD, 8'hC3, 4'hB};
        vecs[10] = '{4'h8, 4'h1, 4'h0, 8'h0F, 4'hD};
        vecs[11] = '{4'hE, 4'h0, 4'h0, 8'h77, 4'hD};
        vecs[12] = '{4'h2, 4'h4, 4'hC, 8'h99, 4'hA};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(4'h0, 4'h0, 4'h0, 8'h00);
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        chk("reset_shares", 32'({out_s3, out_s2, out_s1}), 32'd0);
        rst_n = 1'b1;
        step();
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Table: one entry at a time, which checks 1-cycle latency, the exact shares,
        // the share XOR, a single-cycle out_valid pulse and hold after the pop.
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].s1, vecs[v].s2, vecs[v].s3, vecs[v].rnd);
            exp_sh   = model(vecs[v].s1, vecs[v].s2, vecs[v].s3, vecs[v].rnd);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_shares", v), 32'({out_s3, out_s2, out_s1}), 32'(exp_sh));
            chk($sformatf("vec%0d_xor", v), 32'(out_s1 ^ out_s2 ^ out_s3), 32'(vecs[v].y));
            step();
            chk($sformatf("vec%0d_pulse", v), 32'({out_valid, occupancy}), 32'd0);
            chk($sformatf("vec%0d_hold", v), 32'({out_s3, out_s2, out_s1}), 32'(exp_sh));
        end

        // Cone check: share 1 must not move when only in_s1 changes.
        for (int s = 0; s < 16; s++) begin
            drive(4'(s), 4'h5, 4'hC, 8'h5A);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("cone_s1_%0d", s), 32'(out_s1), 32'(fs(4'h5, 4'hC) ^ 4'hA));
            step();
        end

        // Backpressure: with DEPTH=2, two inputs are accepted and the third is held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        hist.delete();
        for (int n = 0; n < 3; n++) begin
            drive(4'(n + 3), 4'(n * 5), 4'h9, 8'(n * 37 + 1));
            hist.push_back(model(4'(n + 3), 4'(n * 5), 4'h9, 8'(n * 37 + 1)));
            step();
            chk($sformatf("bp_occ%0d", n), 32'(occupancy), (n == 0) ? 32'd1 : 32'd2);
            chk($sformatf("bp_rdy%0d", n), 32'(in_ready), (n == 0) ? 32'd1 : 32'd0);
        end
        chk("bp_head0", 32'({out_s3, out_s2, out_s1}), 32'(hist[0]));
        // Pop while full with in_valid still high: the held input is not taken.
        out_ready = 1'b1;
        step();
        chk("bp_full_pop_occ", 32'(occupancy), 32'd1);
        chk("bp_full_pop_rdy", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        chk("bp_head1", 32'({out_s3, out_s2, out_s1}), 32'(hist[1]));
        step();
        chk("bp_drained", 32'({out_valid, occupancy}), 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_third", 32'({out_s3, out_s2, out_s1}), 32'(hist[2]));
        step();

        // Streaming: one accept and one pop per cycle keep occupancy at 1.
        in_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            drive(4'(n), 4'(15 - n), 4'(n * 3), 8'(n * 29));
            exp_sh = model(4'(n), 4'(15 - n), 4'(n * 3), 8'(n * 29));
            step();
            chk($sformatf("stream%0d_occ", n), 32'({out_valid, occupancy}), 32'b101);
            chk($sformatf("stream%0d_data", n), 32'({out_s3, out_s2, out_s1}), 32'(exp_sh));
        end
        in_valid = 1'b0;
        step();

        // Random traffic and backpressure against a scoreboard. It includes x=0 and x=F.
        sb.delete();
        for (int it = 0; it < 300; it++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            a  = 4'($urandom);
            b  = 4'($urandom);
            xr = (it % 50 == 5) ? 4'h0 : (it % 50 == 6) ? 4'hF : 4'($urandom);
            drive(a, b, xr ^ a ^ b, 8'($urandom));
            chk("rand_occ", 32'(occupancy), 32'(sb.size()));
            if (out_valid && out_ready) begin
                head = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
                chk("rand_shares", 32'({out_s3, out_s2, out_s1}), 32'(head[11:0]));
                chk("rand_xor", 32'(out_s1 ^ out_s2 ^ out_s3), 32'(q_ref(head[15:12])));
            end
            if (in_valid && in_ready)
                sb.push_back({xr, model(in_s1, in_s2, in_s3, rnd)});
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int it = 0; it < 4; it++) begin
            if (out_valid) begin
                head = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
                chk("drain_shares", 32'({out_s3, out_s2, out_s1}), 32'(head[11:0]));
            end
            step();
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-cycle with two entries queued.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(4'h7, 4'h1, 4'h2, 8'h33);
        step();
        step();
        in_valid = 1'b0;
        chk("arst_pre_occ", 32'(occupancy), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_shares", 32'({out_s3, out_s2, out_s1}), 32'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("arst_ready", 32'({in_ready, out_valid}), 32'b10);
        drive(4'h3, 4'h0, 4'h0, 8'h00);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("arst_resume", 32'({out_valid, out_s1 ^ out_s2 ^ out_s3}), 32'h1B);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
